// File: rtl/fb_scaler.sv
// fb_scaler: framebuffer scan-out stage between the VGA timing generator and the output
// registers. It reads a SRC_W x SRC_H framebuffer from synchronous block RAM, upscales it by
// a per-frame integer factor (1..MAX_SCALE), centres it on the DISP_W x DISP_H display and
// fills the surround with border_rgb. Sync and active are delayed to match the colour path.
//
// Ports:
//   clk, reset         pixel clock; synchronous active-high reset
//   scale              requested scale, latched at frame start (0 or > MAX_SCALE -> 1)
//   in_active/x/y      display enable and pixel position from the timing generator
//   in_hs, in_vs       sync from the timing generator
//   border_rgb         border colour {r,g,b}
//   fb_addr, fb_data   framebuffer read port (data valid one cycle after address)
//   out_r/g/b          colour outputs, 3 clocks after the inputs
//   out_hs, out_vs     sync outputs, aligned with the colour
//
// Optional feature: define FB_SCALER_GRID_EN to draw a red grid on the first row/column of
// every upscaled source pixel when the latched scale is 2 or more.
module fb_scaler #(
  parameter int unsigned SRC_W     = 160,
  parameter int unsigned SRC_H     = 144,
  parameter int unsigned DISP_W    = 640,
  parameter int unsigned DISP_H    = 480,
  parameter int unsigned PIX_W     = 2,
  parameter int unsigned COLOR_W   = 2,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned MAX_SCALE = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             scale,
  input  logic                   in_active,
  input  logic [9:0]             in_x,
  input  logic [9:0]             in_y,
  input  logic                   in_hs,
  input  logic                   in_vs,
  input  logic [3*COLOR_W-1:0]   border_rgb,
  output logic [ADDR_W-1:0]      fb_addr,
  input  logic [PIX_W-1:0]       fb_data,
  output logic [COLOR_W-1:0]     out_r,
  output logic [COLOR_W-1:0]     out_g,
  output logic [COLOR_W-1:0]     out_b,
  output logic                   out_hs,
  output logic                   out_vs
);

  localparam int unsigned SX_W = $clog2(SRC_W + 1);

  // Per-scale window geometry, all elaboration-time constants.
  localparam logic [10:0] WIN_W1 = 11'(SRC_W);
  localparam logic [10:0] WIN_W2 = 11'(SRC_W * 2);
  localparam logic [10:0] WIN_W3 = 11'(SRC_W * 3);
  localparam logic [10:0] WIN_H1 = 11'(SRC_H);
  localparam logic [10:0] WIN_H2 = 11'(SRC_H * 2);
  localparam logic [10:0] WIN_H3 = 11'(SRC_H * 3);
  localparam logic [10:0] OFF_X1 = 11'((DISP_W - SRC_W) / 2);
  localparam logic [10:0] OFF_X2 = 11'((DISP_W - SRC_W * 2) / 2);
  localparam logic [10:0] OFF_X3 = 11'((DISP_W - SRC_W * 3) / 2);
  localparam logic [10:0] OFF_Y1 = 11'((DISP_H - SRC_H) / 2);
  localparam logic [10:0] OFF_Y2 = 11'((DISP_H - SRC_H * 2) / 2);
  localparam logic [10:0] OFF_Y3 = 11'((DISP_H - SRC_H * 3) / 2);

  // Frame and counter state
  logic [1:0]        scale_q, scale_d;
  logic              synced_q, synced_d;
  logic [1:0]        sub_x_q, sub_x_d;
  logic [1:0]        sub_y_q, sub_y_d;
  logic [SX_W-1:0]   src_x_q, src_x_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] fb_addr_d;

  // Pipeline side-band
  logic win_s0_q, act_s0_q, hs_s0_q, vs_s0_q;
  logic win_s1_q, act_s1_q, hs_s1_q, vs_s1_q;

  logic [1:0]   scale_sane, eff_scale, last_sub;
  logic [10:0]  win_w, win_h, off_x, off_y, x_ext, y_ext;
  logic         frame_start, x_hit, y_hit, in_win, row_end;
  logic [1:0]   sub_x_cur, sub_y_cur;
  logic [SX_W-1:0]   src_x_cur;
  logic [ADDR_W-1:0] row_base_cur;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

`ifdef FB_SCALER_GRID_EN
  logic grid_d, grid_s0_q, grid_s1_q;
`endif

  always_comb begin
    scale_sane  = (scale == 2'd0 || 32'(scale) > MAX_SCALE) ? 2'd1 : scale;
    frame_start = in_active && (in_x == 10'd0) && (in_y == 10'd0);
    // On the frame-start cycle itself the freshly latched scale already applies.
    eff_scale   = frame_start ? scale_sane : scale_q;
    last_sub    = eff_scale - 2'd1;
  end

  always_comb begin
    win_w = WIN_W1;
    win_h = WIN_H1;
    off_x = OFF_X1;
    off_y = OFF_Y1;
    case (eff_scale)
      2'd2: begin
        win_w = WIN_W2;
        win_h = WIN_H2;
        off_x = OFF_X2;
        off_y = OFF_Y2;
      end
      2'd3: begin
        win_w = WIN_W3;
        win_h = WIN_H3;
        off_x = OFF_X3;
        off_y = OFF_Y3;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_ext   = {1'b0, in_x};
    y_ext   = {1'b0, in_y};
    x_hit   = (x_ext >= off_x) && (x_ext < off_x + win_w);
    y_hit   = (y_ext >= off_y) && (y_ext < off_y + win_h);
    in_win  = in_active && (synced_q || frame_start) && x_hit && y_hit;
    row_end = (x_ext == off_x + win_w) && y_hit;
  end

  // Frame start clears the counters; the rest of the update then proceeds from zero.
  always_comb begin
    sub_x_cur    = frame_start ? 2'd0 : sub_x_q;
    sub_y_cur    = frame_start ? 2'd0 : sub_y_q;
    src_x_cur    = frame_start ? '0 : src_x_q;
    row_base_cur = frame_start ? '0 : row_base_q;

    scale_d    = frame_start ? scale_sane : scale_q;
    synced_d   = frame_start | synced_q;
    sub_x_d    = sub_x_cur;
    sub_y_d    = sub_y_cur;
    src_x_d    = src_x_cur;
    row_base_d = row_base_cur;
    fb_addr_d  = fb_addr;

    if (in_win) begin
      fb_addr_d = row_base_cur + ADDR_W'(src_x_cur);
      if (sub_x_cur == last_sub) begin
        sub_x_d = 2'd0;
        src_x_d = src_x_cur + 1'b1;
      end else begin
        sub_x_d = sub_x_cur + 2'd1;
      end
    end else if (row_end) begin
      sub_x_d = 2'd0;
      src_x_d = '0;
      if (sub_y_cur == last_sub) begin
        sub_y_d    = 2'd0;
        row_base_d = row_base_cur + ADDR_W'(SRC_W);
      end else begin
        sub_y_d = sub_y_cur + 2'd1;
      end
    end
  end

`ifdef FB_SCALER_GRID_EN
  always_comb begin
    grid_d = in_win && (eff_scale >= 2'd2) && (sub_x_cur == 2'd0 || sub_y_cur == 2'd0);
  end
`endif

  // Output colour, chosen from the stage-1 side-band and the RAM data.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (act_s1_q) begin
      if (win_s1_q) begin
        r_d = ~fb_data;
        g_d = ~fb_data;
        b_d = ~fb_data;
`ifdef FB_SCALER_GRID_EN
        if (grid_s1_q) begin
          r_d = '1;
          g_d = '0;
          b_d = '0;
        end
`endif
      end else begin
        {r_d, g_d, b_d} = border_rgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scale_q    <= 2'd1;
      synced_q   <= 1'b0;
      sub_x_q    <= 2'd0;
      sub_y_q    <= 2'd0;
      src_x_q    <= '0;
      row_base_q <= '0;
      fb_addr    <= '0;
      win_s0_q   <= 1'b0;
      act_s0_q   <= 1'b0;
      hs_s0_q    <= 1'b0;
      vs_s0_q    <= 1'b0;
      win_s1_q   <= 1'b0;
      act_s1_q   <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_hs     <= 1'b0;
      out_vs     <= 1'b0;
`ifdef FB_SCALER_GRID_EN
      grid_s0_q  <= 1'b0;
      grid_s1_q  <= 1'b0;
`endif
    end else begin
      scale_q    <= scale_d;
      synced_q   <= synced_d;
      sub_x_q    <= sub_x_d;
      sub_y_q    <= sub_y_d;
      src_x_q    <= src_x_d;
      row_base_q <= row_base_d;
      fb_addr    <= fb_addr_d;
      win_s0_q   <= in_win;
      act_s0_q   <= in_active;
      hs_s0_q    <= in_hs;
      vs_s0_q    <= in_vs;
      win_s1_q   <= win_s0_q;
      act_s1_q   <= act_s0_q;
      hs_s1_q    <= hs_s0_q;
      vs_s1_q    <= vs_s0_q;
      out_r      <= r_d;
      out_g      <= g_d;
      out_b      <= b_d;
      out_hs     <= hs_s1_q;
      out_vs     <= vs_s1_q;
`ifdef FB_SCALER_GRID_EN
      grid_s0_q  <= grid_d;
      grid_s1_q  <= grid_s0_q;
`endif
    end
  end

endmodule
